// File: rtl/adc_conv_arbiter.sv
// Round-robin arbiter sharing one ADC conversion engine between NUM_REQ requesters.
// Issues a single conversion per grant and returns the result (or a timeout error) to the winner.
module adc_conv_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CH_W    = 1,
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*CH_W-1:0]  req_ch,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [DATA_W-1:0]        resp_data,
    output logic                     resp_err,
    output logic                     conv_start,
    output logic [CH_W-1:0]          conv_ch,
    input  logic                     conv_done,
    input  logic [DATA_W-1:0]        conv_data,
    output logic                     busy
);

    localparam int unsigned IDX_W    = $clog2(NUM_REQ);
    localparam int unsigned SUM_W    = IDX_W + 1;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [15:0]      timer;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [SUM_W-1:0] sum;
    logic [CH_W-1:0]  win_ch;

    // First requester at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        sum       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr} + SUM_W'(i);
            if (sum >= SUM_W'(NUM_REQ)) begin
                sum = sum - SUM_W'(NUM_REQ);
            end
            if (!win_found && req_valid[sum[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        win_ch = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_ch = req_ch[i*CH_W +: CH_W];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == StIdle && win_found) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= StIdle;
            rr_ptr     <= '0;
            grant_idx  <= '0;
            timer      <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            conv_start <= 1'b0;
            conv_ch    <= '0;
            busy       <= 1'b0;
        end else begin
            conv_start <= 1'b0;
            resp_valid <= '0;
            case (state)
                StIdle: begin
                    if (win_found) begin
                        grant_idx  <= win_idx;
                        conv_ch    <= win_ch;
                        conv_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= StIssue;
                    end
                end
                StIssue: begin
                    timer <= '0;
                    state <= StWait;
                end
                StWait: begin
                    timer <= timer + 16'd1;
                    // A completion on the last timeout cycle still counts as success.
                    if (conv_done) begin
                        resp_data             <= conv_data;
                        resp_err              <= 1'b0;
                        resp_valid[grant_idx] <= 1'b1;
                        state                 <= StResp;
                    end else if (timer == TMO_LAST) begin
                        resp_data             <= '0;
                        resp_err              <= 1'b1;
                        resp_valid[grant_idx] <= 1'b1;
                        state                 <= StResp;
                    end
                end
                StResp: begin
                    rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
                    busy   <= 1'b0;
                    state  <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_conv_arbiter.sv
// Randomized self-checking bench for adc_conv_arbiter against a transaction-level model.
module tb_adc_conv_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 48;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ch = '0;
    logic [3:0]  req_ready;
    logic [3:0]  resp_valid;
    logic [11:0] resp_data;
    logic        resp_err;
    logic        conv_start;
    logic [0:0]  conv_ch;
    logic        conv_done = 1'b0;
    logic [11:0] conv_data = '0;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    int          model_rr = 0;
    logic [11:0] last_data = '0;
    logic        last_err = 1'b0;

    adc_conv_arbiter #(
        .NUM_REQ(NREQ),
        .CH_W   (1),
        .DATA_W (12),
        .TIMEOUT(TMO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ch    (req_ch),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .resp_err  (resp_err),
        .conv_start(conv_start),
        .conv_ch   (conv_ch),
        .conv_done (conv_done),
        .conv_data (conv_data),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] mask);
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = (model_rr + i) % NREQ;
            if (mask[idx]) return idx;
        end
        return 0;
    endfunction

    function automatic logic [3:0] onehot(input int g);
        logic [3:0] one;
        one = 4'b0001;
        return one << g;
    endfunction

    // Entered and left at posedge+1 with the DUT idle. done_at is the WAIT cycle
    // carrying conv_done; a value outside 0..TMO-1 means the engine never answers.
    task automatic txn(input logic [3:0] mask, input logic [3:0] chs, input int done_at,
                       input logic [11:0] data);
        int          g;
        logic        exp_err;
        logic [11:0] exp_data;
        g        = pick(mask);
        exp_err  = !(done_at >= 0 && done_at < TMO);
        exp_data = exp_err ? 12'h000 : data;
        req_valid = mask;
        req_ch    = chs;
        @(negedge clk);
        check("req_ready", 32'(req_ready), 32'(onehot(g)));
        check("busy_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
        req_valid = mask & ~onehot(g);
        @(negedge clk);
        check("conv_start", 32'(conv_start), 32'd1);
        check("conv_ch", 32'(conv_ch), 32'(chs[g]));
        check("ready_issue", 32'(req_ready), 32'd0);
        check("busy_issue", 32'(busy), 32'd1);
        @(posedge clk); #1;
        for (int k = 0; k < TMO; k++) begin
            conv_done = (k == done_at);
            conv_data = (k == done_at) ? data : 12'($urandom);
            @(negedge clk);
            if (k == 0) check("start_once", 32'(conv_start), 32'd0);
            check("resp_wait", 32'(resp_valid), 32'd0);
            check("ready_wait", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
            conv_done = 1'b0;
            if (k == done_at) break;
        end
        req_valid = '0;
        @(negedge clk);
        check("resp_valid", 32'(resp_valid), 32'(onehot(g)));
        check("resp_data", 32'(resp_data), 32'(exp_data));
        check("resp_err", 32'(resp_err), 32'(exp_err));
        model_rr  = (g + 1) % NREQ;
        last_data = exp_data;
        last_err  = exp_err;
        @(posedge clk); #1;
        @(negedge clk);
        check("resp_pulse", 32'(resp_valid), 32'd0);
        check("busy_back", 32'(busy), 32'd0);
        check("data_hold", 32'(resp_data), 32'(exp_data));
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_wait();
        int g;
        g = pick(4'b1111);
        req_valid = 4'b1111;
        req_ch    = 4'($urandom);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'(onehot(g)));
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n  = 1'b1;
        model_rr = 0;
        last_data = '0;
        last_err  = 1'b0;
        conv_done = 1'b1;
        conv_data = 12'h123;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(conv_start), 32'd0);
        @(posedge clk); #1;
        conv_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_resp", 32'(resp_valid), 32'd0);
            check("rst_data", 32'(resp_data), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic spurious_done();
        conv_done = 1'b1;
        conv_data = 12'($urandom);
        @(negedge clk);
        check("spur_busy", 32'(busy), 32'd0);
        check("spur_start", 32'(conv_start), 32'd0);
        @(posedge clk); #1;
        conv_done = 1'b0;
        @(negedge clk);
        check("spur_resp", 32'(resp_valid), 32'd0);
        check("spur_data", 32'(resp_data), 32'(last_data));
        check("spur_err", 32'(resp_err), 32'(last_err));
        check("spur_busy2", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        @(negedge clk);
        check("rst_state_busy", 32'(busy), 32'd0);
        check("rst_state_resp", 32'(resp_valid), 32'd0);
        check("rst_state_start", 32'(conv_start), 32'd0);
        check("rst_state_data", 32'(resp_data), 32'd0);
        check("rst_state_err", 32'(resp_err), 32'd0);
        check("rst_state_ch", 32'(conv_ch), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        txn(4'b0001, 4'b0001, 39, 12'hA5C);

        for (int i = 0; i < 8; i++) begin
            txn(4'b1111, 4'($urandom), int'($urandom_range(0, 10)), 12'($urandom));
        end

        txn(4'b1111, 4'($urandom), -1, 12'hFFF);
        txn(4'b1111, 4'($urandom), 3, 12'h3C3);
        txn(4'b0110, 4'($urandom), TMO - 1, 12'h5A5);

        spurious_done();

        for (int i = 0; i < 4; i++) begin
            txn(4'b1010, 4'($urandom), int'($urandom_range(0, 6)), 12'($urandom));
        end

        txn(4'b0100, 4'b0100, 2, 12'h777);
        reset_mid_wait();
        txn(4'b1111, 4'($urandom), 1, 12'h0F0);

        for (int i = 0; i < 30; i++) begin
            int d;
            d = int'($urandom_range(0, TMO + 8));
            if (d >= TMO) d = -1;
            txn(4'($urandom_range(1, 15)), 4'($urandom), d, 12'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_conv_arbiter.md
Name: adc_conv_arbiter

Overview:
- Shares one ADC conversion engine (SPI front end producing 12-bit results, 2+ channels) between several on-chip requesters, such as the motion loop, the telemetry logger and the HPS bridge.
- Grants requesters round-robin, issues a single-conversion command, waits for completion or timeout, and returns the tagged result to the winner.
- Sits between the requester logic and the ADC serial engine, in the FPGA_CLK1_50 domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CH_W, 1, width of channel select field
DATA_W, 12, conversion result width
TIMEOUT, 1023, clk cycles in WAIT before declaring failure (1..65535)

Ports:
clk  in  1  50 MHz system clock
reset_n  in  1  reset, synchronous, active-low
req_valid  in  NUM_REQ  per-requester conversion request, held until accepted
req_ch  in  NUM_REQ*CH_W  channel select; requester i uses bits [i*CH_W +: CH_W]
req_ready  out  NUM_REQ  one-hot accept pulse
resp_valid  out  NUM_REQ  one-hot result pulse to the granted requester
resp_data  out  DATA_W  result, valid while any resp_valid is high
resp_err  out  1  timeout flag, qualified by resp_valid
conv_start  out  1  one-cycle command pulse to the ADC engine
conv_ch  out  CH_W  channel for the command; stable from ISSUE until leaving WAIT
conv_done  in  1  one-cycle completion pulse from the ADC engine
conv_data  in  DATA_W  result, valid with conv_done
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset_n low at a clk edge):
  - state=IDLE, rr_ptr=0, timer=0, grant index=0.
  - req_ready, resp_valid, conv_start, resp_err and busy are all 0; resp_data=0; conv_ch=0.
  - Reset mid-transaction abandons the transaction: no response is issued, and a later conv_done is ignored because the block is in IDLE.
- State IDLE:
  - If any req_valid is set, pick winner g = first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - req_ready[g] is driven high combinationally in this cycle.
  - At the clk edge: capture conv_ch = req_ch[g], register g, go to ISSUE.
  - With no requests, stay in IDLE.
- State ISSUE: conv_start=1 for exactly this cycle; timer cleared; go to WAIT.
- State WAIT:
  - timer increments each cycle.
  - conv_done=1: latch conv_data into resp_data, set err=0, go to RESP.
  - Else if timer==TIMEOUT-1: set resp_data=0, err=1, go to RESP.
  - If conv_done and the timeout condition occur in the same cycle, conv_done wins (err=0).
- State RESP:
  - resp_valid[g]=1 and resp_err=err for exactly one cycle.
  - rr_ptr <= (g+1) mod NUM_REQ; go to IDLE.
- Latency:
  - Accept to conv_start: 1 cycle.
  - conv_done to resp_valid: 1 cycle.
  - Minimum request-to-request spacing: 4 cycles plus ADC conversion time.
- conv_done in IDLE, ISSUE or RESP is ignored and has no state effect.
- resp_data and resp_err hold their last values outside RESP.
- A requester dropping req_valid before acceptance is allowed; it is simply not granted.
- Fairness: a continuously requesting requester is granted within NUM_REQ transactions.
- The rr_ptr wrap from NUM_REQ-1 goes to 0.
- req_ready is never asserted outside IDLE, and at most one bit is set at a time.

Test Plan:
- Single request: req_valid=4'b0001, ch=1; engine returns conv_done with 12'hA5C 40 cycles after conv_start. Required: req_ready[0] in the request cycle, conv_start one cycle later with conv_ch=1, resp_valid[0] one cycle after conv_done, resp_data=12'hA5C, resp_err=0.
- Round-robin: all four requesters held valid for 8 transactions. Required grant order 0,1,2,3,0,1,2,3 and no resp_valid on a non-granted index.
- Timeout: TIMEOUT=16, engine never responds. Required: resp_valid[g] exactly 16 cycles after the WAIT entry edge, resp_err=1, resp_data=0, block returns to IDLE and serves the next request normally.
- Collision: conv_done asserted in the same cycle the timer reaches TIMEOUT-1. Required: resp_err=0 and resp_data=conv_data.
- Reset mid-WAIT: assert reset_n low for 1 cycle during WAIT, then pulse conv_done. Required: no resp_valid, busy=0, rr_ptr=0 so requester 0 wins the next arbitration.
- Spurious and sparse traffic: conv_done pulsed while in IDLE causes no output change. Only requesters 1 and 3 valid gives alternating grants 1,3,1,3.
